fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 67 ++++++
 rtl/fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, the NOP
// word shown on an empty decode interface, and the sequential PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_ABORT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instruction} entries; DEPTH must be a power of two so
// the pointers wrap for free. The head reads straight out of storage.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [ENTRY_W-1:0]         push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [ENTRY_W-1:0]         head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ENTRY_W-1:0] EMPTY_ENTRY = {{(ENTRY_W-32){1'b0}}, NOP_INSTR};

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    always_comb begin
        pop_ok   = pop_i && (count_q != '0) && !flush_i;
        push_ok  = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = (count_q == '0) ? EMPTY_ENTRY : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC fetch into a prefetch queue feeding decode,
// with redirect/flush. Define FETCH_UNIT_PERF_EN to build the stall-cycle counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    output logic [XLEN-1:0]          INSTR_MEM_ADDR,
    output logic                     INSTR_MEM_READ,
    input  logic [31:0]              INSTRUCTION,
    input  logic                     INSTR_MEM_BUSYWAIT,
    input  logic                     REDIRECT,
    input  logic [XLEN-1:0]          REDIRECT_PC,
    input  logic                     ID_HOLD,
    output logic                     ID_VALID,
    output logic [XLEN-1:0]          ID_PC,
    output logic [31:0]              ID_INSTRUCTION,
    output logic [$clog2(DEPTH):0]   QUEUE_COUNT,
    output logic [31:0]              FETCH_STALL_CNT
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = XLEN + 32;

    fetch_state_e       state_q, state_d;
    logic [XLEN-1:0]    fpc_q, fpc_d;
    logic               run_q;
    logic               read;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   q_count;
    logic [CNT_W-1:0]   count_nxt;
    logic [ENTRY_W-1:0] head;

    fetch_queue #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_queue (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .push_i      (push),
        .push_data_i ({fpc_q, INSTRUCTION}),
        .pop_i       (pop),
        .flush_i     (REDIRECT),
        .count_o     (q_count),
        .head_o      (head)
    );

    // run_q keeps READ low until the first edge after reset release.
    always_comb begin
        read      = run_q && (state_q == S_FETCH);
        push      = read && !INSTR_MEM_BUSYWAIT && !REDIRECT;
        pop       = (q_count != '0) && !ID_HOLD && !REDIRECT;
        count_nxt = q_count + CNT_W'(push) - CNT_W'(pop);

        state_d = state_q;
        if (REDIRECT) begin
            state_d = (read && INSTR_MEM_BUSYWAIT) ? S_ABORT : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: if (push && (count_nxt == CNT_W'(DEPTH))) state_d = S_FULL;
                S_FULL:  if (count_nxt < CNT_W'(DEPTH))            state_d = S_FETCH;
                S_ABORT: state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end

        fpc_d = fpc_q;
        if (REDIRECT)  fpc_d = REDIRECT_PC & ~XLEN'(3);
        else if (push) fpc_d = fpc_q + XLEN'(PC_INC);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_FETCH;
            fpc_q   <= RESET_VECTOR;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            run_q   <= 1'b1;
        end
    end

`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (read && INSTR_MEM_BUSYWAIT && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign FETCH_STALL_CNT = stall_cnt_q;
`else
    assign FETCH_STALL_CNT = 32'd0;
`endif

    assign INSTR_MEM_ADDR = fpc_q;
    assign INSTR_MEM_READ = read;
    assign ID_VALID       = (q_count != '0);
    assign ID_PC          = head[ENTRY_W-1:32];
    assign ID_INSTRUCTION = head[31:0];
    assign QUEUE_COUNT    = q_count;

endmodule
